// File: rtl/hazard_detection_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_detection_unit_pkg: shared CPU pipeline-register types.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package hazard_detection_unit_pkg;

  localparam int REG_ADDR_W  = 3;
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    reg_addr_t   rs;
    reg_addr_t   rt;
    reg_addr_t   rd;
    logic [15:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    reg_addr_t   rd;
    logic [15:0] alu_out;
  } ex_mem_t;

  typedef struct packed {
    logic        regwrite;
    reg_addr_t   rd;
    logic [15:0] wb_data;
  } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_stall_counter: saturating up-counter of stall cycles.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hazard_stall_counter
  import hazard_detection_unit_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_detection_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_detection_unit: load-use stall detection with stall count. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hazard_detection_unit #(
  parameter int REG_ADDR_W = hazard_detection_unit_pkg::REG_ADDR_W,
  parameter int CNT_W      = hazard_detection_unit_pkg::STALL_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EX_memread,
  input  logic [REG_ADDR_W-1:0] EX_rt,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  output logic                  hazard,
  output logic                  IF_IDwrite,
  output logic                  PCWrite,
  output logic [CNT_W-1:0]      stall_count
);

  logic w_raw_hazard;
  logic w_hazard;

  // Register 0 is compared like any other address.
  assign w_raw_hazard = EX_memread && ((EX_rt == ID_rs) || (EX_rt == ID_rt));
  assign w_hazard     = w_raw_hazard && !reset;

  assign hazard     = w_hazard;
  assign IF_IDwrite = !w_hazard;
  assign PCWrite    = !w_hazard;

  hazard_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hazard),
    .count (stall_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// Directed bench for hazard_detection_unit; a second CNT_W=4 instance
// shares all inputs to exercise counter saturation.
module tb_hazard_detection_unit;

  logic        clk;
  logic        reset;
  logic        EX_memread;
  logic [2:0]  EX_rt;
  logic [2:0]  ID_rs;
  logic [2:0]  ID_rt;
  logic        hazard;
  logic        IF_IDwrite;
  logic        PCWrite;
  logic [15:0] stall_count;
  logic        s_hazard;
  logic        s_IF_IDwrite;
  logic        s_PCWrite;
  logic [3:0]  s_stall_count;

  int n_cmp;
  int n_err;

  hazard_detection_unit dut (
    .clk         (clk),
    .reset       (reset),
    .EX_memread  (EX_memread),
    .EX_rt       (EX_rt),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .hazard      (hazard),
    .IF_IDwrite  (IF_IDwrite),
    .PCWrite     (PCWrite),
    .stall_count (stall_count)
  );

  hazard_detection_unit #(.REG_ADDR_W(3), .CNT_W(4)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .EX_memread  (EX_memread),
    .EX_rt       (EX_rt),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .hazard      (s_hazard),
    .IF_IDwrite  (s_IF_IDwrite),
    .PCWrite     (s_PCWrite),
    .stall_count (s_stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic exp_h);
    chk({tag, "_hazard"}, {31'd0, hazard}, {31'd0, exp_h});
    chk({tag, "_ifid"},   {31'd0, IF_IDwrite}, {31'd0, !exp_h});
    chk({tag, "_pc"},     {31'd0, PCWrite}, {31'd0, !exp_h});
  endtask

  task automatic drive(input logic mr, input logic [2:0] ert, input logic [2:0] rs, input logic [2:0] rt);
    EX_memread = mr;
    EX_rt      = ert;
    ID_rs      = rs;
    ID_rt      = rt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset and idle
    reset = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    chk_ctl("reset_idle", 1'b0);
    chk("reset_cnt", {16'd0, stall_count}, 32'd0);
    chk("reset_sat_cnt", {28'd0, s_stall_count}, 32'd0);

    // No load in EX
    reset = 1'b0;
    drive(1'b0, 3'b001, 3'b011, 3'b010);
    #1;
    chk_ctl("no_hazard", 1'b0);
    tick();
    chk("no_hazard_cnt", {16'd0, stall_count}, 32'd0);

    // rt match
    drive(1'b1, 3'b010, 3'b011, 3'b010);
    #1;
    chk_ctl("rt_match", 1'b1);
    tick();
    chk("rt_match_cnt", {16'd0, stall_count}, 32'd1);

    // rs match, then the load leaves EX
    drive(1'b1, 3'b011, 3'b011, 3'b010);
    #1;
    chk_ctl("rs_match", 1'b1);
    tick();
    drive(1'b0, 3'b100, 3'b011, 3'b010);
    #1;
    chk_ctl("load_cleared", 1'b0);
    chk("load_cleared_cnt", {16'd0, stall_count}, 32'd2);
    tick();
    chk("idle_hold_cnt", {16'd0, stall_count}, 32'd2);

    // Non-load with every address matching
    drive(1'b0, 3'b101, 3'b101, 3'b101);
    #1;
    chk_ctl("no_load_match", 1'b0);
    tick();

    // Register 0 double match counts once
    drive(1'b1, 3'b000, 3'b000, 3'b000);
    #1;
    chk_ctl("r0_double", 1'b1);
    tick();
    chk("r0_double_cnt", {16'd0, stall_count}, 32'd3);

    // Reset mid-stall
    drive(1'b1, 3'b110, 3'b110, 3'b001);
    #1;
    chk_ctl("pre_reset", 1'b1);
    reset = 1'b1;
    #1;
    chk_ctl("reset_mid_stall", 1'b0);
    tick();
    chk("reset_mid_cnt", {16'd0, stall_count}, 32'd0);
    chk("reset_mid_sat_cnt", {28'd0, s_stall_count}, 32'd0);

    // Outputs follow inputs right after reset release
    reset = 1'b0;
    #1;
    chk_ctl("post_reset", 1'b1);
    tick();
    chk("post_reset_cnt", {16'd0, stall_count}, 32'd1);

    // Saturation of the 4-bit instance over 20 more hazard cycles
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sat_cnt", {28'd0, s_stall_count}, (i + 2 > 15) ? 32'd15 : 32'(i + 2));
    end
    chk("wide_cnt", {16'd0, stall_count}, 32'd21);
    chk("sat_hazard", {31'd0, s_hazard}, 32'd1);

    // Reset clears a saturated counter
    reset = 1'b1;
    tick();
    chk("sat_reset_cnt", {28'd0, s_stall_count}, 32'd0);
    chk("wide_reset_cnt", {16'd0, stall_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list SHALL be:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- EX_memread  input  1  instruction in EX is a load.
- EX_rt  input  3  destination register of the load in EX.
- ID_rs  input  3  first source register of the instruction in ID.
- ID_rt  input  3  second source register of the instruction in ID.
- hazard  output  1  load-use stall request; also selects the bubble in the ID/EX control mux.
- IF_IDwrite  output  1  IF/ID register write enable.
- PCWrite  output  1  PC write enable.
- stall_count  output  16  count of stall cycles since reset.
REQ-003 Parameter REG_ADDR_W SHALL have default 3 and set the register-address width.
REQ-004 Parameter CNT_W SHALL have default 16 and set the width of stall_count.

Function
REQ-005 The raw hazard condition SHALL be `EX_memread && ((EX_rt == ID_rs) || (EX_rt == ID_rt))`.
REQ-006 Register 0 SHALL NOT be treated specially; a match on address 0 SHALL raise a hazard.
REQ-007 hazard SHALL be combinational, equal to the raw condition AND NOT reset, with zero-cycle latency.
REQ-008 IF_IDwrite SHALL equal NOT hazard.
REQ-009 PCWrite SHALL equal NOT hazard.
REQ-010 With EX_memread=0, hazard SHALL be 0 regardless of register addresses.
REQ-011 When EX_rt matches both ID_rs and ID_rt, the block SHALL produce a single hazard, with no double counting.
REQ-012 Each stall SHALL last exactly as long as the condition holds. The block SHALL keep no internal stall state beyond stall_count; the pipeline's bubble insertion removes the condition on the next cycle.
REQ-013 stall_count SHALL increment by 1 on each rising clk edge where hazard=1.
REQ-014 stall_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap around.
REQ-015 The block SHALL be free of X-propagation: with all inputs driven to known values, no output SHALL be X.

Reset
REQ-016 While reset=1, hazard SHALL be 0.
REQ-017 While reset=1, IF_IDwrite and PCWrite SHALL both be 1.
REQ-018 On a rising clk edge with reset=1, stall_count SHALL be cleared to 0.
REQ-019 Reset asserted during a stall SHALL deassert hazard immediately (combinationally).
REQ-020 Reset asserted during a stall SHALL clear stall_count at the next rising edge.
REQ-021 Reset SHALL take priority over an increment on the same edge.
REQ-022 After reset deasserts, outputs SHALL follow inputs in the same cycle.

Structure
REQ-023 REG_ADDR_W and the register-address type SHALL reside in the shared CPU package, together with the other pipeline-register definitions (IF_ID, ID_EX, EX_MEM, MEM_WB).
REQ-024 The saturating counter SHALL be one sub-module, hazard_stall_counter, with ports clk, reset, inc and count.
REQ-025 The compare logic SHALL stay in the top-level block.
REQ-026 The block SHALL contain no latches.
REQ-027 stall_count SHALL be the only sequential state in the block.

Verification
REQ-028 Reset and idle: reset=1, EX_memread=0, all addresses 000 -> hazard=0, IF_IDwrite=1, PCWrite=1, stall_count=0 after the first edge.
REQ-029 No hazard: reset=0, EX_memread=0, EX_rt=001, ID_rt=010, ID_rs=011, one cycle -> hazard=0, IF_IDwrite=1, PCWrite=1, stall_count unchanged.
REQ-030 rt match: EX_memread=1, EX_rt=010, ID_rt=010, ID_rs=011 -> hazard=1, IF_IDwrite=0, PCWrite=0, stall_count +1 after the edge.
REQ-031 rs match, then load cleared: EX_memread=1, EX_rt=011, ID_rt=010, ID_rs=011 -> hazard=1. Next cycle EX_memread=0, EX_rt=100 -> hazard=0, IF_IDwrite=1, PCWrite=1, stall_count=2.
REQ-032 Register 0 and double match: EX_memread=1, EX_rt=000, ID_rs=000, ID_rt=000 -> hazard=1, counted once per cycle.
REQ-033 Reset mid-stall: assert reset while hazard=1 -> hazard drops to 0 immediately and stall_count=0 after the next edge.
REQ-034 Saturation: force CNT_W=4 and hold the hazard for 20 cycles -> stall_count stays at 15 with no wrap.
